// File: rtl/fmadd_round_pipe.sv
// Two-stage rounding and packing back end for a half-precision FMADD.
// S1 captures the word and rounding decisions, S2 rounds, packs and flags.
module fmadd_round_pipe #(
    parameter int std  = 15,
    parameter int man  = 9,
    parameter int exp  = 4,
    parameter int biad = 15,
    parameter int W    = 2*man+exp+6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_no,
    input  logic [2:0]   in_rm,
    input  logic         in_overflow,
    input  logic         in_sticky_PN,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [std:0] out_no,
    output logic [3:0]   out_S_Flags,
    input  logic         flag_clr,
    output logic [3:0]   acc_flags
);
    localparam int EW = exp + 1;
    localparam int MW = man + 2;
    // Biased exponent of infinity is 2*bias+1; largest finite is 2*bias.
    localparam logic [EW-1:0] L_EXP_INF = EW'(2*biad+1);
    localparam logic [EW-1:0] L_EXP_MAX = EW'(2*biad);

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    logic          w_en;
    logic          w_xfer;
    logic          w_sign;
    logic [EW-1:0] w_exp;
    logic [MW-1:0] w_mant;
    logic          w_g;
    logic          w_r;
    logic          w_s;
    logic          w_lost;
    logic          w_bad_rm;
    logic          w_inc;
    logic          w_inf;

    logic          r1_valid;
    logic          r1_sign;
    logic [EW-1:0] r1_exp;
    logic [MW-1:0] r1_mant;
    logic          r1_inc;
    logic          r1_inf;
    logic          r1_lost;
    logic          r1_ovf;
    logic          r1_bad_rm;

    logic [MW:0]   w_sum;
    logic          w_exp_up;
    logic [EW:0]   w_exp_rnd;
    logic          w_ovf;
    logic          w_inexact;
    logic          w_unf;
    logic [std:0]  w_res;
    logic [3:0]    w_flags;

    logic          r_out_valid;
    logic [std:0]  r_out_no;
    logic [3:0]    r_flags;
    logic [3:0]    r_acc;

    assign w_en     = ~r_out_valid | out_ready;
    assign w_xfer   = r_out_valid & out_ready;
    assign in_ready = w_en;

    assign w_sign   = in_no[W-1];
    assign w_exp    = in_no[W-2:2*man+4];
    assign w_mant   = in_no[2*man+3:man+2];
    assign w_g      = in_no[man+1];
    assign w_r      = in_no[man];
    assign w_s      = (|in_no[man-1:0]) | in_sticky_PN;
    assign w_lost   = w_g | w_r | w_s;
    assign w_bad_rm = in_rm > RM_RMM;

    // Undefined modes fall through to the RNE defaults.
    always_comb begin
        w_inc = w_g & (w_r | w_s | w_mant[0]);
        w_inf = 1'b1;
        case (in_rm)
            RM_RTZ: begin
                w_inc = 1'b0;
                w_inf = 1'b0;
            end
            RM_RDN: begin
                w_inc = w_sign & w_lost;
                w_inf = w_sign;
            end
            RM_RUP: begin
                w_inc = ~w_sign & w_lost;
                w_inf = ~w_sign;
            end
            RM_RMM: w_inc = w_g;
            default: ;
        endcase
    end

    assign w_sum     = {1'b0, r1_mant} + {{MW{1'b0}}, r1_inc};
    // Carry-out, or a subnormal that rounded up into the normal range.
    assign w_exp_up  = w_sum[MW] | (~r1_mant[MW-1] & w_sum[MW-1]);
    assign w_exp_rnd = {1'b0, r1_exp} + {{EW{1'b0}}, w_exp_up};
    assign w_ovf     = r1_ovf | (w_exp_rnd >= {1'b0, L_EXP_INF});
    assign w_inexact = r1_lost | w_ovf;
    assign w_unf     = (r1_exp == '0) & w_inexact & ~w_ovf;
    assign w_flags   = {r1_bad_rm, w_ovf, w_unf, w_inexact};

    assign w_res = !w_ovf ? {r1_sign, w_exp_rnd[EW-1:0], w_sum[MW-2:0]}
                 : r1_inf ? {r1_sign, L_EXP_INF, {(MW-1){1'b0}}}
                 :          {r1_sign, L_EXP_MAX, {(MW-1){1'b1}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r1_sign     <= 1'b0;
            r1_exp      <= '0;
            r1_mant     <= '0;
            r1_inc      <= 1'b0;
            r1_inf      <= 1'b0;
            r1_lost     <= 1'b0;
            r1_ovf      <= 1'b0;
            r1_bad_rm   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_no    <= '0;
            r_flags     <= '0;
            r_acc       <= '0;
        end else begin
            if (w_en) begin
                r1_valid    <= in_valid;
                r1_sign     <= w_sign;
                r1_exp      <= w_exp;
                r1_mant     <= w_mant;
                r1_inc      <= w_inc;
                r1_inf      <= w_inf;
                r1_lost     <= w_lost;
                r1_ovf      <= in_overflow;
                r1_bad_rm   <= w_bad_rm;
                r_out_valid <= r1_valid;
                if (r1_valid) begin
                    r_out_no <= w_res;
                    r_flags  <= w_flags;
                end
            end
            if (flag_clr) begin
                r_acc <= w_xfer ? r_flags : 4'b0000;
            end else if (w_xfer) begin
                r_acc <= r_acc | r_flags;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_no      = r_out_no;
    assign out_S_Flags = r_flags;
    assign acc_flags   = r_acc;
endmodule
